// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
// Each request is held stable until its one-cycle gnt; each rvalid is a one-cycle pulse.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic            m_ready;
    logic            m_rvalid;
    logic [XLEN-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters, one transaction at a time.
// Data has fixed priority; a starvation counter forces a fetch win after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t          state_q, state_d;
    owner_t          owner_q;
    logic            m_we_q;
    logic [XLEN-1:0] m_addr_q;
    logic [XLEN-1:0] m_wdata_q;
    logic [3:0]      starve_q;

    logic pick_d, pick_i, accept, done;

    always_comb begin
        pick_d  = bus.d_req && !(bus.i_req && (starve_q == STARVE_LIM));
        pick_i  = bus.i_req && !pick_d;
        accept  = (state_q == ISSUE) && bus.m_ready;
        done    = (state_q == WAIT) && bus.m_rvalid;
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_d || pick_i) state_d = ISSUE;
            ISSUE:   if (accept) state_d = WAIT;
            WAIT:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m_req    = (state_q == ISSUE);
        bus.m_we     = m_we_q;
        bus.m_addr   = m_addr_q;
        bus.m_wdata  = m_wdata_q;
        bus.i_gnt    = accept && (owner_q == OWN_I);
        bus.d_gnt    = accept && (owner_q == OWN_D);
        bus.i_rvalid = done && (owner_q == OWN_I);
        bus.d_rvalid = done && (owner_q == OWN_D);
        // Read data is forced to zero unless its rvalid is high.
        bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
        busy         = (state_q != IDLE);
        state_dbg    = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            starve_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (pick_d || pick_i)) begin
                owner_q   <= pick_d ? OWN_D : OWN_I;
                m_we_q    <= pick_d && bus.d_we;
                m_addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
                m_wdata_q <= pick_d ? bus.d_wdata : '0;
            end else if (done) begin
                owner_q <= OWN_NONE;
            end
            // Count data grants that made a pending fetch wait; a fetch grant resets the count.
            if (bus.i_gnt) begin
                starve_q <= 4'd0;
            end else if (bus.d_gnt && bus.i_req && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store with stalls, priority, starvation,
// reset during a transaction and stray memory responses.
module tb_mem_port_arbiter;
    localparam int XLEN = 32;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];   // expected grant owner: 1 = data, 0 = fetch

    mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_gnt, bus.d_gnt,
                 bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, busy};
    endfunction

    // Runs one transaction from IDLE with requests already pending; memory accepts at once
    // and answers one cycle later. The granted owner is compared with the head of exp_q.
    task automatic serve(input logic drop_d, input logic drop_i);
        logic got_d;
        logic [0:0] exp_owner;
        tick();
        bus.m_ready = 1'b1;
        #1;
        check("serve_gnt_count", 32'(bus.i_gnt) + 32'(bus.d_gnt), 32'd1);
        got_d = bus.d_gnt;
        if (exp_q.size() == 0) begin
            check("serve_exp_q_empty", 32'd0, 32'd1);
        end else begin
            exp_owner = exp_q.pop_front();
            check("serve_owner", 32'(got_d), 32'(exp_owner));
        end
        tick();
        bus.m_ready = 1'b0;
        if (got_d && drop_d) bus.d_req = 1'b0;
        if (!got_d && drop_i) bus.i_req = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h5A5A_0000 + 32'(n_checks);
        #1;
        check("serve_rvalid_own", got_d ? 32'(bus.d_rvalid) : 32'(bus.i_rvalid), 32'd1);
        check("serve_rvalid_other", got_d ? 32'(bus.i_rvalid) : 32'(bus.d_rvalid), 32'd0);
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", 32'(any_out()), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single fetch, minimum latency
        bus.i_req = 1; bus.i_addr = 32'h0000_0010; bus.m_ready = 1;
        #1;
        check("fetch_c0_busy", 32'(busy), 32'd0);
        tick();
        check("fetch_c1_m_req", 32'(bus.m_req), 32'd1);
        check("fetch_c1_m_addr", bus.m_addr, 32'h0000_0010);
        check("fetch_c1_m_we", 32'(bus.m_we), 32'd0);
        check("fetch_c1_i_gnt", 32'(bus.i_gnt), 32'd1);
        check("fetch_c1_d_gnt", 32'(bus.d_gnt), 32'd0);
        tick();
        bus.i_req = 0; bus.m_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0050_0093;
        #1;
        check("fetch_c2_m_req", 32'(bus.m_req), 32'd0);
        check("fetch_c2_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        check("fetch_c2_i_rdata", bus.i_rdata, 32'h0050_0093);
        check("fetch_c2_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        tick();
        bus.m_rvalid = 0; bus.m_rdata = '0;
        #1;
        check("fetch_c3_busy", 32'(busy), 32'd0);

        // Store with three stall cycles
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("store_stall_m_req", 32'(bus.m_req), 32'd1);
            check("store_stall_m_we", 32'(bus.m_we), 32'd1);
            check("store_stall_m_addr", bus.m_addr, 32'h0000_0100);
            check("store_stall_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
            check("store_stall_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
            tick();
        end
        bus.m_ready = 1;
        #1;
        check("store_d_gnt", 32'(bus.d_gnt), 32'd1);
        check("store_i_gnt", 32'(bus.i_gnt), 32'd0);
        tick();
        bus.d_req = 0; bus.d_we = 0; bus.m_ready = 0; bus.m_rdata = 32'hAAAA_AAAA;
        #1;
        check("store_wait_d_gnt", 32'(bus.d_gnt), 32'd0);
        check("store_wait_rdata_zero", bus.d_rdata, 32'd0);
        check("store_wait_busy", 32'(busy), 32'd1);
        tick();
        bus.m_rvalid = 1; bus.m_rdata = '0;
        #1;
        check("store_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("store_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        tick();
        bus.m_rvalid = 0;
        #1;
        check("store_done_busy", 32'(busy), 32'd0);

        // Simultaneous requests: data first, then fetch
        bus.i_req = 1; bus.i_addr = 32'h0000_0020;
        bus.d_req = 1; bus.d_addr = 32'h0000_0200;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        serve(1'b1, 1'b1);
        serve(1'b1, 1'b1);
        check("simul_busy", 32'(busy), 32'd0);

        // Starvation: both held continuously; counter must restart from zero here
        bus.i_req = 1; bus.d_req = 1;
        for (int k = 0; k < 10; k++) exp_q.push_back((k % 5 == 4) ? 1'b0 : 1'b1);
        for (int k = 0; k < 10; k++) serve(1'b0, 1'b0);
        check("starve_q_drained", 32'(exp_q.size()), 32'd0);
        bus.i_req = 0; bus.d_req = 0;

        // Reset while waiting for the memory response
        tick();
        bus.i_req = 1; bus.i_addr = 32'h0000_0040; bus.m_ready = 1;
        tick();
        tick();
        bus.i_req = 0; bus.m_ready = 0;
        #1;
        check("rst_mid_in_wait", 32'(state_dbg), 32'(S_WAIT));
        #1 rst = 1'b0;
        #1;
        check("rst_mid_outputs", 32'(any_out()), 32'd0);
        check("rst_mid_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b1;
        tick();
        bus.m_rvalid = 1; bus.m_rdata = 32'h0000_1234;
        #1;
        check("rst_late_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        check("rst_late_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        check("rst_late_state", 32'(state_dbg), 32'(S_IDLE));

        // Stray responses in IDLE and ISSUE
        tick();
        #1;
        check("stray_idle_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0300;
        tick();
        #1;
        check("stray_issue_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        check("stray_issue_state", 32'(state_dbg), 32'(S_ISSUE));
        tick();
        check("stray_issue_hold", 32'(state_dbg), 32'(S_ISSUE));
        check("stray_issue_m_addr", bus.m_addr, 32'h0000_0300);
        bus.m_rvalid = 0; bus.m_ready = 1;
        #1;
        check("stray_load_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        bus.d_req = 0; bus.m_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hCAFE_0001;
        #1;
        check("stray_load_d_rdata", bus.d_rdata, 32'hCAFE_0001);
        check("stray_load_i_rdata", bus.i_rdata, 32'd0);
        tick();
        bus.m_rvalid = 0; bus.m_rdata = '0;
        #1;
        check("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
